// File: rtl/adder_share_pkg.sv
// Shared types and the round-robin pick helper for the adder-sharing arbiter.
package adder_share_pkg;
  localparam int DATA_W  = 32;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic              sub;
  } op_t;

  // First set bit of valid[n-1:0] searching upward from ptr+1 with wrap.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0] ptr, input int n);
    pick_t p;
    int    k;
    p = '0;
    for (int off = 1; off <= MAX_REQ; off++) begin
      if (off <= n && !p.found) begin
        k = (int'(ptr) + off) % n;
        if (valid[k[2:0]]) begin
          p.found = 1'b1;
          p.idx   = k[2:0];
        end
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/Full_Adder32Bit.sv
// 32-bit ripple-carry adder shared by all requesters.
module Full_Adder32Bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[32];
endmodule

// File: rtl/adder_share_arbiter_rr.sv
// Combinational round-robin pick: one-hot grant, winner index and found flag.
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               found
);
  logic [MAX_REQ-1:0] vpad;
  pick_t              pick;

  always_comb begin
    vpad = '0;
    vpad[NUM_REQ-1:0] = valid;
    pick  = rr_pick(vpad, 3'(ptr), NUM_REQ);
    found = pick.found;
    idx   = ID_W'(pick.idx);
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++)
      grant[i] = pick.found && (int'(pick.idx) == i);
  end
endmodule

// File: rtl/adder_share_arbiter.sv
// One shared 32-bit adder, round-robin among NUM_REQ requesters, one op in flight.
// Optional signed-overflow output rsp_ovf under `ADDER_SHARE_ARB_OVF_EN.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_cin,
  input  logic [NUM_REQ-1:0]        req_sub,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic                      rsp_cout
`ifdef ADDER_SHARE_ARB_OVF_EN
  ,
  output logic                      rsp_ovf
`endif
);
  state_t            state;
  op_t               op;
  op_t               op_sel;
  logic [ID_W-1:0]   ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   win;
  logic              found;
  logic [DATA_W-1:0] b_eff;
  logic              cin_eff;
  logic [DATA_W-1:0] sum;
  logic              cout;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .valid(req_valid), .ptr(ptr), .grant(grant), .idx(win), .found(found)
  );

  assign req_ready = (state == IDLE) ? grant : '0;

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(win) == i) begin
        op_sel.a   = req_a[i*DATA_W +: DATA_W];
        op_sel.b   = req_b[i*DATA_W +: DATA_W];
        op_sel.cin = req_cin[i];
        op_sel.sub = req_sub[i];
      end
    end
  end

  // Subtract is A + ~B + ~borrow_in, so cout reads as "no borrow".
  assign b_eff   = op.sub ? ~op.b   : op.b;
  assign cin_eff = op.sub ? ~op.cin : op.cin;

  Full_Adder32Bit u_add (.a(op.a), .b(b_eff), .cin(cin_eff), .sum(sum), .cout(cout));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= ID_W'(NUM_REQ-1);
      op        <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
`ifdef ADDER_SHARE_ARB_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (found) begin
          op     <= op_sel;
          rsp_id <= win;
          ptr    <= win;
          state  <= EXEC;
        end
        EXEC: begin
          rsp_sum   <= sum;
          rsp_cout  <= cout;
`ifdef ADDER_SHARE_ARB_OVF_EN
          rsp_ovf   <= (op.a[31] == b_eff[31]) && (sum[31] != op.a[31]);
`endif
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
